// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: compare, victim writeback, line fill, retry.
// Ports: clk_i/rst_i; CPU rd_i/wr_i; array hit_i/valid_i/dirty_i; mem_stall_i;
//        stall_o/done_o/cache_hit_o/err_o; cache comp/wr/sel/offset; mem wr/rd/sel/offset.
module cache_ctrl_fsm #(
    parameter int WORDS   = 4,
    parameter int OFF_W   = 2,
    parameter int MEM_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic             hit_i,
    input  logic             valid_i,
    input  logic             dirty_i,
    input  logic             mem_stall_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             cache_hit_o,
    output logic             err_o,
    output logic             comp_o,
    output logic             cache_wr_o,
    output logic             cache_sel_o,
    output logic [OFF_W-1:0] cache_offset_o,
    output logic             mem_wr_o,
    output logic             mem_rd_o,
    output logic             mem_sel_o,
    output logic [OFF_W-1:0] mem_offset_o
);

    typedef enum logic [1:0] {IDLE, WB, FILL, RETRY} state_e;

    localparam logic [OFF_W:0] LAST = (OFF_W+1)'(WORDS - 1);
    localparam logic [OFF_W:0] CNT  = (OFF_W+1)'(WORDS);

    state_e           state_q, state_d;
    logic [OFF_W:0]   cnt_q, cnt_d;
    logic [OFF_W:0]   ret_q, ret_d;
    logic             op_q, op_d;
    logic [MEM_LAT-1:0] pv_q;
    logic [OFF_W-1:0] pi_q [MEM_LAT];

    logic             req;
    logic             issue;
    logic             push;
    logic             pop;
    logic [OFF_W-1:0] pop_idx;

    assign req     = rd_i ^ wr_i;
    assign issue   = (state_q == FILL) && (cnt_q < CNT);
    assign push    = issue && !mem_stall_i;
    assign pop     = pv_q[MEM_LAT-1];
    assign pop_idx = pi_q[MEM_LAT-1];

    // State, counters and the memory return pipeline
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ret_q   <= '0;
            op_q    <= 1'b0;
            pv_q    <= '0;
            for (int j = 0; j < MEM_LAT; j++) pi_q[j] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            op_q    <= op_d;
            pv_q[0] <= push;
            pi_q[0] <= cnt_q[OFF_W-1:0];
            for (int j = 1; j < MEM_LAT; j++) begin
                pv_q[j] <= pv_q[j-1];
                pi_q[j] <= pi_q[j-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (req && !(hit_i && valid_i)) begin
                    op_d    = wr_i;
                    cnt_d   = '0;
                    ret_d   = '0;
                    state_d = (dirty_i && valid_i) ? WB : FILL;
                end
            end
            WB: begin
                if (!mem_stall_i) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (push) cnt_d = cnt_q + 1'b1;
                if (pop) begin
                    ret_d = ret_q + 1'b1;
                    // last word written this cycle; retry the access next
                    if (ret_q == LAST) begin
                        cnt_d   = '0;
                        ret_d   = '0;
                        state_d = RETRY;
                    end
                end
            end
            RETRY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o        = 1'b0;
        done_o         = 1'b0;
        cache_hit_o    = 1'b0;
        err_o          = 1'b0;
        comp_o         = 1'b0;
        cache_wr_o     = 1'b0;
        cache_sel_o    = 1'b0;
        cache_offset_o = '0;
        mem_wr_o       = 1'b0;
        mem_rd_o       = 1'b0;
        mem_sel_o      = 1'b0;
        mem_offset_o   = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (rd_i && wr_i) begin
                        err_o = 1'b1;
                    end else if (req) begin
                        comp_o     = 1'b1;
                        cache_wr_o = wr_i;
                        if (hit_i && valid_i) begin
                            done_o      = 1'b1;
                            cache_hit_o = 1'b1;
                        end else begin
                            stall_o = 1'b1;
                        end
                    end
                end
                WB: begin
                    stall_o        = 1'b1;
                    mem_wr_o       = 1'b1;
                    mem_offset_o   = cnt_q[OFF_W-1:0];
                    cache_sel_o    = 1'b1;
                    cache_offset_o = cnt_q[OFF_W-1:0];
                end
                FILL: begin
                    stall_o = 1'b1;
                    if (issue) begin
                        mem_rd_o     = 1'b1;
                        mem_sel_o    = 1'b1;
                        mem_offset_o = cnt_q[OFF_W-1:0];
                    end
                    if (pop) begin
                        cache_wr_o     = 1'b1;
                        cache_sel_o    = 1'b1;
                        cache_offset_o = pop_idx;
                    end
                end
                RETRY: begin
                    comp_o     = 1'b1;
                    cache_wr_o = op_q;
                    done_o     = 1'b1;
                end
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: expected events queued per request,
// a negedge monitor pops and compares them as the DUT shows them.
module tb_cache_ctrl_fsm;

    localparam int W   = 4;
    localparam int OW  = 2;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst, rd, wr, hit, valid, dirty, mem_stall;
    logic stall, done, cache_hit, err, comp, cache_wr, cache_sel;
    logic mem_wr, mem_rd, mem_sel;
    logic [OW-1:0] cache_offset, mem_offset;

    cache_ctrl_fsm #(.WORDS(W), .OFF_W(OW), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .rd_i(rd), .wr_i(wr), .hit_i(hit),
        .valid_i(valid), .dirty_i(dirty), .mem_stall_i(mem_stall),
        .stall_o(stall), .done_o(done), .cache_hit_o(cache_hit), .err_o(err),
        .comp_o(comp), .cache_wr_o(cache_wr), .cache_sel_o(cache_sel),
        .cache_offset_o(cache_offset), .mem_wr_o(mem_wr), .mem_rd_o(mem_rd),
        .mem_sel_o(mem_sel), .mem_offset_o(mem_offset)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int off; bit h; bit w;} ev_t;
    ev_t wr_q[$], rd_q[$], fw_q[$], dn_q[$], er_q[$];
    ev_t me;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  stl [256];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({stall, done, cache_hit, err, comp, cache_wr, cache_sel,
                     cache_offset, mem_wr, mem_rd, mem_sel, mem_offset});
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (mem_wr) begin
            chk("wb_memsel", int'(mem_sel), 0);
            chk("wb_stall", int'(stall), 1);
            chk("wb_coff", int'(cache_offset), int'(mem_offset));
            if (!mem_stall) begin
                chk("wb_pending", int'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    me = wr_q.pop_front();
                    chk("wb_off", int'(mem_offset), me.off);
                    chk("wb_cyc", cyc, me.c);
                end
            end
        end
        if (mem_rd) begin
            chk("rd_memsel", int'(mem_sel), 1);
            chk("rd_stall", int'(stall), 1);
            if (!mem_stall) begin
                chk("rd_pending", int'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    me = rd_q.pop_front();
                    chk("rd_off", int'(mem_offset), me.off);
                    chk("rd_cyc", cyc, me.c);
                end
            end
        end
        if (cache_wr && cache_sel) begin
            chk("fill_comp", int'(comp), 0);
            chk("fill_pending", int'(fw_q.size() > 0), 1);
            if (fw_q.size() > 0) begin
                me = fw_q.pop_front();
                chk("fill_off", int'(cache_offset), me.off);
                chk("fill_cyc", cyc, me.c);
            end
        end
        if (done) begin
            chk("done_pending", int'(dn_q.size() > 0), 1);
            chk("done_stall", int'(stall), 0);
            chk("done_comp", int'(comp), 1);
            if (dn_q.size() > 0) begin
                me = dn_q.pop_front();
                chk("done_cyc", cyc, me.c);
                chk("done_hit", int'(cache_hit), int'(me.h));
                chk("done_cwr", int'(cache_wr), int'(me.w));
            end
        end
        if (err) begin
            chk("err_pending", int'(er_q.size() > 0), 1);
            chk("err_quiet", int'({mem_rd, mem_wr, cache_wr, done, stall}), 0);
            if (er_q.size() > 0) begin
                me = er_q.pop_front();
                chk("err_cyc", cyc, me.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        wr_q.delete(); rd_q.delete(); fw_q.delete(); dn_q.delete(); er_q.delete();
    endtask

    // Reference: issues are accepted in order on non-stalled cycles starting
    // at T+1; each read returns LAT cycles later; done one cycle after the last.
    task automatic run_txn(input bit r, input bit w, input bit h,
                           input bit v, input bit d);
        int T, t, last, D;
        ev_t e;
        tick();
        T = cyc;
        rd = r; wr = w; hit = h; valid = v; dirty = d; mem_stall = 1'b0;
        D = T;
        e = '{c: T, off: 0, h: 1'b0, w: 1'b0};
        if (r && w) begin
            er_q.push_back(e);
        end else if (r || w) begin
            if (h && v) begin
                e.h = 1'b1; e.w = w;
                dn_q.push_back(e);
            end else begin
                t = T + 1;
                if (d && v) begin
                    for (int k = 0; k < W; k++) begin
                        while (stl[t - T]) t++;
                        wr_q.push_back('{c: t, off: k, h: 1'b0, w: 1'b0});
                        t++;
                    end
                end
                last = t;
                for (int k = 0; k < W; k++) begin
                    while (stl[t - T]) t++;
                    rd_q.push_back('{c: t, off: k, h: 1'b0, w: 1'b0});
                    fw_q.push_back('{c: t + LAT, off: k, h: 1'b0, w: 1'b0});
                    last = t;
                    t++;
                end
                D = last + LAT + 1;
                dn_q.push_back('{c: D, off: 0, h: 1'b0, w: w});
            end
        end
        for (int c = T + 1; c <= D; c++) begin
            tick();
            mem_stall = stl[c - T];
        end
        @(negedge clk);
        #1;
        chk("drain", wr_q.size() + rd_q.size() + fw_q.size() + dn_q.size() + er_q.size(), 0);
        flush();
    endtask

    task automatic clr_stl();
        for (int i = 0; i < 256; i++) stl[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd = 0; wr = 0; hit = 1; valid = 1; dirty = 0; mem_stall = 0;
        clr_stl();
        tick();
        @(negedge clk);
        chk("rst_outs", outs(), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 0);

        run_txn(1, 0, 1, 1, 0);          // read hit
        run_txn(1, 0, 0, 1, 0);          // clean read miss
        run_txn(0, 1, 0, 1, 1);          // dirty write miss
        stl[2] = 1'b1;
        run_txn(1, 0, 0, 1, 0);          // stall on 2nd issue
        clr_stl();
        run_txn(1, 1, 1, 1, 0);          // illegal
        run_txn(1, 0, 0, 0, 1);          // invalid dirty line is clean

        // Reset during the 3rd fill cycle
        tick();
        rd = 1; wr = 0; hit = 0; valid = 0; dirty = 0; mem_stall = 0;
        rd_q.push_back('{c: cyc + 1, off: 0, h: 1'b0, w: 1'b0});
        rd_q.push_back('{c: cyc + 2, off: 1, h: 1'b0, w: 1'b0});
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rd_drained", rd_q.size(), 0);
        chk("midrst_outs", outs(), 0);
        flush();
        tick();
        rst = 1'b0; rd = 0;
        @(negedge clk);
        chk("postrst_outs", outs(), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("postrst_quiet", outs(), 0);
        end
        run_txn(0, 1, 1, 1, 1);          // write hit right after reset

        for (int n = 0; n < 40; n++) begin
            clr_stl();
            for (int i = 1; i < 120; i++) stl[i] = ($urandom_range(3) == 0);
            run_txn($urandom_range(1), $urandom_range(1), $urandom_range(1),
                    $urandom_range(1), $urandom_range(1));
        end
        clr_stl();
        run_txn(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
